ecall_io_responder: RTL and testbench
=====================================

ECALL_IO_RESPONDER -- requirements
Module: ecall_io_responder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 230000, meaning consecutive stable cycles before the button level is accepted (10 ms at 23 MHz).
REQ-002 SHALL have port clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ecall_req  input  1  CPU is stalled on ecall, held high until ecall_done.
REQ-005 SHALL have port ecall_code  input  32  value of a7 at the ecall.
REQ-006 SHALL have port a0_in  input  32  value of a0 at the ecall.
REQ-007 SHALL have port switch_in  input  16  raw switch bank.
REQ-008 SHALL have port test_sel  input  3  test-case selector switches.
REQ-009 SHALL have port confirm_btn  input  1  raw, asynchronous confirm button.
REQ-010 SHALL have port ecall_done  output  1  one-cycle pulse that releases the CPU.
REQ-011 SHALL have port wb_en  output  1  write wb_data to a0; pulses only together with ecall_done.
REQ-012 SHALL have port wb_data  output  32  value written back to a0.
REQ-013 SHALL have port disp_value  output  32  value latched for the seven-segment display.
REQ-014 SHALL have port led_status  output  8  bit0 halted, bit1 waiting for test case, bit7 waiting for input, other bits 0.

Function
REQ-015 confirm_btn SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE, HALT.
REQ-017 IDLE with ecall_req=1: code 5 (read int) or 12 (read test case) -> WAIT_PRESS; code 1 (print int) -> latch a0_in into disp_value, -> DONE; code 10 (exit) -> HALT; any other code -> DONE.
REQ-018 WAIT_PRESS: on debounced rising edge, capture {16'h0, switch_in} (code 5) or {29'h0, test_sel} (code 12) into wb_data, -> WAIT_RELEASE.
REQ-019 WAIT_RELEASE: on debounced falling edge -> DONE; one press SHALL satisfy exactly one read.
REQ-020 DONE: ecall_done=1 for exactly one cycle; wb_en=1 in that cycle only for codes 5/12; -> IDLE next cycle.
REQ-021 Latency: print/unknown -> ecall_done in the cycle after acceptance; read -> ecall_done in the cycle after the debounced release.
REQ-022 If ecall_req falls in WAIT_PRESS or WAIT_RELEASE: -> IDLE, no ecall_done, no wb_en, wb_data unchanged.
REQ-023 Button pressed while IDLE (no pending read) SHALL be ignored; a button already held when a read begins SHALL require release and a new press.
REQ-024 HALT is absorbing until reset; ecall_done never asserts; led_status[0]=1.
REQ-025 led_status[7]=1 in WAIT_PRESS/WAIT_RELEASE for code 5; led_status[1]=1 in the same states for code 12.
REQ-026 Debounce counter SHALL saturate, not wrap; width = clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-027 Reset SHALL force: state IDLE, ecall_done 0, wb_en 0, wb_data 0, disp_value 0, led_status 0, synchronizer and debounced level 0, counter 0.
REQ-028 Reset asserted mid-read SHALL abandon the read with no ecall_done pulse, including on release.

Structure
REQ-029 ECALL code constants (1, 5, 10, 12) and the FSM state encoding SHALL live in a shared package, reusable by Controller-side code.
REQ-030 Synchronizer plus debouncer SHALL be one sub-module, btn_debounce, exposing the debounced level and rise/fall pulses.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-031 code 1, a0_in=32'h0000_1234 -> disp_value=32'h1234, ecall_done one cycle later, wb_en=0.
REQ-032 code 5, switch_in=16'hBEEF, clean press/release -> led_status=8'h80 while waiting; one ecall_done with wb_en=1, wb_data=32'h0000_BEEF.
REQ-033 code 5, button bouncing 3-cycle pulses, then steady -> no capture during bounce; exactly one ecall_done.
REQ-034 code 12, test_sel=3'b101, button held before request -> no completion until release+press; wb_data=32'h5, led_status=8'h02 while waiting.
REQ-035 code 10 -> led_status=8'h01, no ecall_done for 100 cycles; further requests ignored; reset -> all outputs 0.
REQ-036 reset asserted in WAIT_RELEASE -> IDLE, no ecall_done, wb_data=0.

Source files
------------

// File: rtl/ecall_io_responder_pkg.sv
// Shared ecall definitions: syscall codes, responder FSM states, LED masks.
package ecall_io_responder_pkg;

  localparam logic [31:0] ECALL_PRINT_INT = 32'd1;
  localparam logic [31:0] ECALL_READ_INT  = 32'd5;
  localparam logic [31:0] ECALL_EXIT      = 32'd10;
  localparam logic [31:0] ECALL_READ_TEST = 32'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_DONE,
    ST_HALT
  } state_e;

  typedef enum logic {
    RD_INT,
    RD_TEST
  } read_kind_e;

  localparam logic [7:0] LED_HALT      = 8'h01;
  localparam logic [7:0] LED_WAIT_TEST = 8'h02;
  localparam logic [7:0] LED_WAIT_INT  = 8'h80;

endpackage

// File: rtl/ecall_io_responder_if.sv
// CPU-side ecall handshake: request, arguments and write-back response.
interface ecall_io_responder_if;
  logic        ecall_req;
  logic [31:0] ecall_code;
  logic [31:0] a0_in;
  logic        ecall_done;
  logic        wb_en;
  logic [31:0] wb_data;

  modport master (
    output ecall_req, ecall_code, a0_in,
    input  ecall_done, wb_en, wb_data
  );

  modport slave (
    input  ecall_req, ecall_code, a0_in,
    output ecall_done, wb_en, wb_data
  );
endinterface

// File: rtl/ecall_io_responder_btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for a raw push button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 230000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic          level_q;
  logic          rise_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          differ;
  logic          flip;

  // Count consecutive cycles where the synchronized input disagrees with the accepted level.
  always_comb begin
    differ  = sync_q[1] ^ level_q;
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    flip    = differ && (cnt_inc == CNT_MAX);
    cnt_d   = (!differ || flip) ? '0 : cnt_inc;
  end

  // Synchronizer, accepted level and one-cycle edge pulses aligned with the level change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= flip ? sync_q[1] : level_q;
      rise_q  <= flip &  sync_q[1];
      fall_q  <= flip & ~sync_q[1];
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ecall_io_responder.sv
// Services CPU ecalls against board I/O: display print, switch/test-select reads, exit.
module ecall_io_responder
  import ecall_io_responder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 230000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecall_req,
  input  logic [31:0] ecall_code,
  input  logic [31:0] a0_in,
  input  logic [15:0] switch_in,
  input  logic [2:0]  test_sel,
  input  logic        confirm_btn,
  output logic        ecall_done,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [31:0] disp_value,
  output logic [7:0]  led_status
);

  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (confirm_btn),
    .level_o (btn_level),
    .rise_o  (btn_rise),
    .fall_o  (btn_fall)
  );

  state_e      state_q;
  read_kind_e  kind_q;
  logic        done_q;
  logic        wb_en_q;
  logic [31:0] wb_data_q;
  logic [31:0] rd_data_q;
  logic [31:0] disp_q;
  logic [7:0]  led_q;

  // Ecall FSM with registered outputs. The sampled read value is staged in rd_data_q and
  // only published to wb_data on completion, so an abandoned read leaves wb_data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      kind_q    <= RD_INT;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      rd_data_q <= '0;
      disp_q    <= '0;
      led_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ecall_req) begin
            if (ecall_code == ECALL_PRINT_INT) begin
              disp_q  <= a0_in;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (ecall_code == ECALL_READ_INT) begin
              kind_q  <= RD_INT;
              led_q   <= LED_WAIT_INT;
              state_q <= ST_WAIT_PRESS;
            end else if (ecall_code == ECALL_READ_TEST) begin
              kind_q  <= RD_TEST;
              led_q   <= LED_WAIT_TEST;
              state_q <= ST_WAIT_PRESS;
            end else if (ecall_code == ECALL_EXIT) begin
              led_q   <= LED_HALT;
              state_q <= ST_HALT;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_WAIT_PRESS: begin
          if (!ecall_req) begin
            led_q   <= '0;
            state_q <= ST_IDLE;
          end else if (btn_rise && btn_level) begin
            rd_data_q <= (kind_q == RD_INT) ? {16'h0, switch_in} : {29'h0, test_sel};
            state_q   <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!ecall_req) begin
            led_q   <= '0;
            state_q <= ST_IDLE;
          end else if (btn_fall) begin
            wb_data_q <= rd_data_q;
            wb_en_q   <= 1'b1;
            done_q    <= 1'b1;
            led_q     <= '0;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_HALT: begin
          led_q   <= LED_HALT;
          state_q <= ST_HALT;
        end
        default: begin
          led_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ecall_done = done_q;
  assign wb_en      = wb_en_q;
  assign wb_data    = wb_data_q;
  assign disp_value = disp_q;
  assign led_status = led_q;

endmodule

// File: tb/tb_ecall_io_responder.sv
// Randomized self-checking bench for ecall_io_responder with a short debounce window.
module tb_ecall_io_responder;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] switch_in = '0;
  logic [2:0]  test_sel = '0;
  logic        confirm_btn = 1'b0;
  logic [31:0] disp_value;
  logic [7:0]  led_status;

  ecall_io_responder_if cpu ();

  ecall_io_responder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .ecall_req   (cpu.ecall_req),
    .ecall_code  (cpu.ecall_code),
    .a0_in       (cpu.a0_in),
    .switch_in   (switch_in),
    .test_sel    (test_sel),
    .confirm_btn (confirm_btn),
    .ecall_done  (cpu.ecall_done),
    .wb_en       (cpu.wb_en),
    .wb_data     (cpu.wb_data),
    .disp_value  (disp_value),
    .led_status  (led_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Completion monitor: counts done pulses, remembers the write-back seen with each,
  // and counts any wb_en seen without ecall_done.
  int          done_cnt = 0;
  int          stray_wb = 0;
  logic        last_wb_en = 1'b0;
  logic [31:0] last_wb_data = '0;
  always @(negedge clk) begin
    if (cpu.ecall_done === 1'b1) begin
      done_cnt++;
      last_wb_en   = cpu.wb_en;
      last_wb_data = cpu.wb_data;
    end else if (cpu.wb_en === 1'b1) begin
      stray_wb++;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drives one complete read ecall and reports what was observed.
  task automatic do_read(input logic [31:0] code, input logic [15:0] sw, input logic [2:0] sel,
                         input int hold, input bit bounce,
                         output logic [7:0] led_wait, output int early_done,
                         output int lat, output bit got, output int total_done);
    int base;
    base = done_cnt;
    switch_in = bounce ? ~sw : sw;
    test_sel  = bounce ? ~sel : sel;
    cpu.ecall_code = code;
    cpu.ecall_req  = 1'b1;
    tick(3);
    led_wait = led_status;
    if (bounce) begin
      for (int b = 0; b < 3; b++) begin
        confirm_btn = 1'b1; tick(3);
        confirm_btn = 1'b0; tick(3);
      end
      switch_in = sw;
      test_sel  = sel;
    end
    confirm_btn = 1'b1;
    tick(hold);
    confirm_btn = 1'b0;
    early_done = done_cnt - base;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick(1);
      lat++;
      if (done_cnt != base) got = 1'b1;
    end
    cpu.ecall_req = 1'b0;
    tick(10);
    total_done = done_cnt - base;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    checks++; if (cpu.ecall_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cpu.ecall_done); end
    checks++; if (cpu.wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b want 0", cpu.wb_en); end
    checks++; if (cpu.wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h want 0", cpu.wb_data); end
    checks++; if (disp_value !== 32'h0) begin errors++; $display("FAIL reset_disp got %h want 0", disp_value); end
    checks++; if (led_status !== 8'h0) begin errors++; $display("FAIL reset_led got %h want 0", led_status); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_print;
    logic [31:0] a0;
    int base;
    for (int i = 0; i < 5; i++) begin
      a0 = (i == 0) ? 32'h0000_1234 : $urandom;
      base = done_cnt;
      cpu.ecall_code = 32'd1;
      cpu.a0_in      = a0;
      cpu.ecall_req  = 1'b1;
      tick(1);
      checks++; if (cpu.ecall_done !== 1'b1) begin errors++; $display("FAIL print_done_latency got %b want 1", cpu.ecall_done); end
      checks++; if (cpu.wb_en !== 1'b0) begin errors++; $display("FAIL print_wb_en got %b want 0", cpu.wb_en); end
      checks++; if (disp_value !== a0) begin errors++; $display("FAIL print_disp got %h want %h", disp_value, a0); end
      cpu.ecall_req = 1'b0;
      tick(3);
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL print_done_count got %0d want 1", done_cnt - base); end
    end
  endtask

  task automatic test_unknown;
    logic [31:0] code;
    logic [31:0] prev_disp;
    int base;
    for (int i = 0; i < 4; i++) begin
      code = $urandom_range(0, 40);
      while (code == 1 || code == 5 || code == 10 || code == 12) code = $urandom_range(0, 40);
      prev_disp = disp_value;
      base = done_cnt;
      cpu.ecall_code = code;
      cpu.a0_in      = $urandom;
      cpu.ecall_req  = 1'b1;
      tick(1);
      checks++; if (cpu.ecall_done !== 1'b1) begin errors++; $display("FAIL unknown_done got %b want 1 code %0d", cpu.ecall_done, code); end
      checks++; if (cpu.wb_en !== 1'b0) begin errors++; $display("FAIL unknown_wb_en got %b want 0", cpu.wb_en); end
      cpu.ecall_req = 1'b0;
      tick(3);
      checks++; if (disp_value !== prev_disp) begin errors++; $display("FAIL unknown_disp got %h want %h", disp_value, prev_disp); end
      checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL unknown_done_count got %0d want 1", done_cnt - base); end
    end
  endtask

  // Reference rules for a read: value width by code, LED by code, completion only after a
  // release that has been stable for at least D cycles.
  task automatic test_reads;
    logic [31:0] code, exp_data;
    logic [15:0] sw;
    logic [2:0]  sel;
    logic [7:0]  led_w, exp_led;
    int early, lat, total, hold;
    bit got, bounce;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin code = 32'd5; sw = 16'hBEEF; sel = 3'd0; bounce = 1'b0; hold = 12; end
      else if (i == 1) begin code = 32'd5; sw = 16'($urandom); sel = 3'd0; bounce = 1'b1; hold = 12; end
      else begin
        code = ($urandom_range(0, 1) == 0) ? 32'd5 : 32'd12;
        sw = 16'($urandom); sel = 3'($urandom); bounce = 1'($urandom_range(0, 1));
        hold = $urandom_range(D + 4, 25);
      end
      exp_data = (code == 32'd5) ? {16'h0, sw} : {29'h0, sel};
      exp_led  = (code == 32'd5) ? 8'h80 : 8'h02;
      do_read(code, sw, sel, hold, bounce, led_w, early, lat, got, total);
      checks++; if (led_w !== exp_led) begin errors++; $display("FAIL read%0d_led got %h want %h", i, led_w, exp_led); end
      checks++; if (early != 0) begin errors++; $display("FAIL read%0d_early_done got %0d want 0", i, early); end
      checks++; if (!got || lat < D || lat > D + 6) begin errors++; $display("FAIL read%0d_latency got %0d want %0d..%0d", i, lat, D, D + 6); end
      checks++; if (last_wb_en !== 1'b1) begin errors++; $display("FAIL read%0d_wb_en got %b want 1", i, last_wb_en); end
      checks++; if (last_wb_data !== exp_data) begin errors++; $display("FAIL read%0d_wb_data got %h want %h", i, last_wb_data, exp_data); end
      checks++; if (total != 1) begin errors++; $display("FAIL read%0d_done_count got %0d want 1", i, total); end
      checks++; if (led_status !== 8'h00) begin errors++; $display("FAIL read%0d_led_after got %h want 0", i, led_status); end
    end
  endtask

  task automatic test_held_before;
    int base, waited;
    confirm_btn = 1'b1;
    tick(12);
    base = done_cnt;
    test_sel = 3'b101;
    cpu.ecall_code = 32'd12;
    cpu.ecall_req  = 1'b1;
    tick(15);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL held_no_done_pressed got %0d want 0", done_cnt - base); end
    checks++; if (led_status !== 8'h02) begin errors++; $display("FAIL held_led got %h want 02", led_status); end
    confirm_btn = 1'b0;
    tick(15);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL held_no_done_release got %0d want 0", done_cnt - base); end
    confirm_btn = 1'b1;
    tick(12);
    confirm_btn = 1'b0;
    waited = 0;
    while (done_cnt == base && waited < 40) begin tick(1); waited++; end
    cpu.ecall_req = 1'b0;
    tick(5);
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL held_done_count got %0d want 1", done_cnt - base); end
    checks++; if (last_wb_data !== 32'h5) begin errors++; $display("FAIL held_wb_data got %h want 5", last_wb_data); end
    checks++; if (last_wb_en !== 1'b1) begin errors++; $display("FAIL held_wb_en got %b want 1", last_wb_en); end
  endtask

  task automatic test_abort;
    logic [31:0] prev;
    int base;
    prev = cpu.wb_data;
    base = done_cnt;
    switch_in = 16'($urandom);
    cpu.ecall_code = 32'd5;
    cpu.ecall_req  = 1'b1;
    tick(3);
    confirm_btn = 1'b1;
    tick(12);
    cpu.ecall_req = 1'b0;
    tick(3);
    checks++; if (led_status !== 8'h00) begin errors++; $display("FAIL abort_led got %h want 0", led_status); end
    confirm_btn = 1'b0;
    tick(15);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL abort_release_done got %0d want 0", done_cnt - base); end
    checks++; if (cpu.wb_data !== prev) begin errors++; $display("FAIL abort_wb_data got %h want %h", cpu.wb_data, prev); end
    cpu.ecall_code = 32'd12;
    cpu.ecall_req  = 1'b1;
    tick(5);
    cpu.ecall_req = 1'b0;
    confirm_btn = 1'b1; tick(12);
    confirm_btn = 1'b0; tick(15);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL abort_press_done got %0d want 0", done_cnt - base); end
    checks++; if (stray_wb != 0) begin errors++; $display("FAIL wb_en_without_done got %0d want 0", stray_wb); end
  endtask

  task automatic test_reset_mid_read;
    int base;
    base = done_cnt;
    test_sel = 3'($urandom);
    cpu.ecall_code = 32'd12;
    cpu.ecall_req  = 1'b1;
    tick(3);
    confirm_btn = 1'b1;
    tick(12);
    reset = 1'b1;
    cpu.ecall_req = 1'b0;
    tick(2);
    reset = 1'b0;
    confirm_btn = 1'b0;
    tick(20);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL midreset_done got %0d want 0", done_cnt - base); end
    checks++; if (cpu.wb_data !== 32'h0) begin errors++; $display("FAIL midreset_wb_data got %h want 0", cpu.wb_data); end
    checks++; if (led_status !== 8'h00) begin errors++; $display("FAIL midreset_led got %h want 0", led_status); end
    checks++; if (disp_value !== 32'h0) begin errors++; $display("FAIL midreset_disp got %h want 0", disp_value); end
  endtask

  task automatic test_halt;
    logic [31:0] prev_disp;
    int base;
    base = done_cnt;
    cpu.ecall_code = 32'd10;
    cpu.ecall_req  = 1'b1;
    tick(1);
    checks++; if (led_status !== 8'h01) begin errors++; $display("FAIL halt_led got %h want 01", led_status); end
    tick(100);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL halt_done got %0d want 0", done_cnt - base); end
    cpu.ecall_req = 1'b0;
    tick(2);
    prev_disp = disp_value;
    cpu.ecall_code = 32'd1;
    cpu.a0_in      = $urandom | 32'h1;
    cpu.ecall_req  = 1'b1;
    tick(10);
    cpu.ecall_code = 32'd5;
    confirm_btn = 1'b1; tick(12);
    confirm_btn = 1'b0; tick(15);
    checks++; if (done_cnt != base) begin errors++; $display("FAIL halt_ignore_done got %0d want 0", done_cnt - base); end
    checks++; if (disp_value !== prev_disp) begin errors++; $display("FAIL halt_disp got %h want %h", disp_value, prev_disp); end
    checks++; if (led_status !== 8'h01) begin errors++; $display("FAIL halt_led_hold got %h want 01", led_status); end
    cpu.ecall_req = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    checks++; if (led_status !== 8'h00) begin errors++; $display("FAIL halt_reset_led got %h want 0", led_status); end
    checks++; if ({cpu.ecall_done, cpu.wb_en} !== 2'b00) begin errors++; $display("FAIL halt_reset_ctl got %b want 00", {cpu.ecall_done, cpu.wb_en}); end
    checks++; if (cpu.wb_data !== 32'h0 || disp_value !== 32'h0) begin errors++; $display("FAIL halt_reset_data got %h/%h want 0/0", cpu.wb_data, disp_value); end
  endtask

  initial begin
    cpu.ecall_req  = 1'b0;
    cpu.ecall_code = '0;
    cpu.a0_in      = '0;
    test_reset();
    test_print();
    test_unknown();
    test_reads();
    test_held_before();
    test_abort();
    test_print();
    test_reset_mid_read();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog_timeout got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
